ase_umsg_engine: RTL and testbench
==================================

ASE_UMSG_ENGINE -- requirements
Module: ase_umsg_engine

Interface
REQ-001 SHALL have parameter NUM_UMSG, default 8, number of UMsg slots (power of 2, 2..64).
REQ-002 SHALL have parameter TIMER_WIDTH, default 6, width of the hint and data delay timers.
REQ-003 SHALL have parameter DATA_WIDTH, default 512, UMsg payload width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port cfg_hint_en  in  1  global hint-mode enable.
REQ-007 SHALL have port hint_delay  in  TIMER_WIDTH  cycles to wait before a hint is sent.
REQ-008 SHALL have port data_delay  in  TIMER_WIDTH  cycles to wait before data is sent.
REQ-009 SHALL have port cmd_valid  in  1  UMsg write command valid.
REQ-010 SHALL have port cmd_ready  out  1  command accept.
REQ-011 SHALL have port cmd_id  in  $clog2(NUM_UMSG)  target slot.
REQ-012 SHALL have port cmd_hint  in  1  command requests a hint before the data.
REQ-013 SHALL have port cmd_data  in  DATA_WIDTH  UMsg payload.
REQ-014 SHALL have port out_valid  out  1  UMsg output valid.
REQ-015 SHALL have port out_ready  in  1  downstream accept.
REQ-016 SHALL have port out_id  out  $clog2(NUM_UMSG)  slot of the output message.
REQ-017 SHALL have port out_hint  out  1  1 = hint (umsg_type), 0 = data message.
REQ-018 SHALL have port out_data  out  DATA_WIDTH  payload; all zero for a hint.
REQ-019 SHALL have port slot_busy  out  NUM_UMSG  per-slot state != Idle.
REQ-020 SHALL have port coalesce_cnt  out  32  count of commands merged into a pending slot.
REQ-021 SHALL have port sent_cnt  out  32  count of completed output handshakes.

Function
REQ-022 Each slot SHALL run an independent FSM with states Idle, HintWait, SendHint, DataWait and SendData, plus a data register and a TIMER_WIDTH down-counter.
REQ-023 A command SHALL be accepted on the edge where cmd_valid && cmd_ready; cmd_ready SHALL be combinational and equal to (state[cmd_id] != SendData).
REQ-024 Idle + accept: SHALL store cmd_data; if cmd_hint && cfg_hint_en, go to HintWait with timer=hint_delay; otherwise go to DataWait with timer=data_delay.
REQ-025 HintWait/DataWait: if timer==0, go to SendHint/SendData respectively; otherwise decrement the timer; a delay of 0 therefore gives a 1-cycle wait.
REQ-026 Accept to a slot in HintWait, SendHint or DataWait: SHALL overwrite the data register, SHALL NOT restart the timer or change state, SHALL ignore cmd_hint, and SHALL increment coalesce_cnt.
REQ-027 Slots in SendHint or SendData SHALL request the output; a round-robin arbiter SHALL choose among them, starting the search at rr_ptr.
REQ-028 The output register SHALL load the winner when (!out_valid || out_ready) and at least one slot requests; out_valid SHALL be 1 after any load, and 0 after a handshake with no load.
REQ-029 On load, the winning slot SHALL change state: SendHint goes to DataWait with timer=data_delay; SendData goes to Idle. rr_ptr SHALL become winner+1 (mod NUM_UMSG).
REQ-030 out_id, out_hint and out_data SHALL be held stable while out_valid && !out_ready.
REQ-031 out_data for a data message SHALL be the slot's data register at load time; a write in the same cycle as the load SHALL NOT appear in that message.
REQ-032 If an accept and a SendHint load hit the same slot on the same edge, the data overwrite and the DataWait transition SHALL both take effect, and coalesce_cnt SHALL increment.
REQ-033 sent_cnt SHALL increment on each out_valid && out_ready; both counters SHALL wrap modulo 2^32.
REQ-034 Changing cfg_hint_en, hint_delay or data_delay SHALL affect only later timer loads and state entries.

Reset
REQ-035 rst_n low SHALL asynchronously force: all slots Idle, timers 0, data registers 0, rr_ptr 0, out_valid 0, out_id/out_hint/out_data 0, slot_busy 0, coalesce_cnt 0, sent_cnt 0.
REQ-036 Assertion of rst_n mid-operation SHALL discard all pending and in-flight UMsgs with no output; operation SHALL resume on the first clk edge after rst_n rises.

Verification
REQ-037 cfg_hint_en=1, hint_delay=3, data_delay=2, out_ready=1, cmd id=2, hint=1, data=0xA5 -> hint (out_id=2, out_hint=1, out_data=0) valid 5 edges after accept; data message (out_data=0xA5) valid 4 edges after hint load; sent_cnt=2.
REQ-038 cfg_hint_en=0, data_delay=0, cmd id=0, hint=1 -> no hint; data message valid 2 edges after accept.
REQ-039 Slot 1 in DataWait receives 3 more commands (last data=0x77) -> single data message with 0x77, coalesce_cnt=3, timer not restarted.
REQ-040 Slots 0,3,5 enter SendData together, out_ready=1 -> outputs in order 0,3,5; then slot 1 and slot 4 simultaneously -> 1 before 4 (rr_ptr=6 wraps).
REQ-041 out_ready=0 for 10 cycles with output pending -> out_* stable; cmd to that slot (in SendData) sees cmd_ready=0; after out_ready=1, cmd_ready=1.
REQ-042 rst_n pulsed low while 4 slots are busy and out_valid=1 -> all outputs and counters 0 immediately, no stale messages afterward.

Source files
------------

// File: rtl/ase_umsg_engine.sv
// ase_umsg_engine: per-slot UMsg scheduler. Each slot optionally sends a hint,
// waits out programmable delays, then sends its data. Commands arriving while a
// slot is pending are merged into it. A round-robin arbiter feeds one
// registered valid/ready output port.
module ase_umsg_engine #(
    parameter int NUM_UMSG    = 8,
    parameter int TIMER_WIDTH = 6,
    parameter int DATA_WIDTH  = 512
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_hint_en,
    input  logic [TIMER_WIDTH-1:0]      hint_delay,
    input  logic [TIMER_WIDTH-1:0]      data_delay,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [$clog2(NUM_UMSG)-1:0] cmd_id,
    input  logic                        cmd_hint,
    input  logic [DATA_WIDTH-1:0]       cmd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(NUM_UMSG)-1:0] out_id,
    output logic                        out_hint,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [NUM_UMSG-1:0]         slot_busy,
    output logic [31:0]                 coalesce_cnt,
    output logic [31:0]                 sent_cnt
);

    localparam int ID_W = $clog2(NUM_UMSG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HINT_WAIT,
        S_SEND_HINT,
        S_DATA_WAIT,
        S_SEND_DATA
    } slot_state_t;

    slot_state_t            state  [NUM_UMSG];
    logic [TIMER_WIDTH-1:0] timer  [NUM_UMSG];
    logic [DATA_WIDTH-1:0]  data_q [NUM_UMSG];

    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     winner;
    logic                any_req;
    logic [NUM_UMSG-1:0] req;
    logic [NUM_UMSG-1:0] cmd_hit;
    logic [NUM_UMSG-1:0] win_hit;
    logic                accept;
    logic                load;
    logic                coalesce;

    // A slot in SendData must not be written: its message is still waiting for the port
    assign cmd_ready = (state[cmd_id] != S_SEND_DATA);
    assign accept    = cmd_valid && cmd_ready;
    assign load      = any_req && (!out_valid || out_ready);
    assign coalesce  = accept && (state[cmd_id] != S_IDLE);

    // Per-slot decode: output requests, busy flags and one-hot command/winner hits
    always_comb begin
        req       = '0;
        slot_busy = '0;
        cmd_hit   = '0;
        win_hit   = '0;
        for (int i = 0; i < NUM_UMSG; i++) begin
            req[i]       = (state[i] == S_SEND_HINT) || (state[i] == S_SEND_DATA);
            slot_busy[i] = (state[i] != S_IDLE);
            cmd_hit[i]   = accept && (cmd_id == ID_W'(i));
            win_hit[i]   = load && (winner == ID_W'(i));
        end
    end

    // Round-robin search for the first requesting slot at or after rr_ptr
    always_comb begin
        any_req = 1'b0;
        winner  = rr_ptr;
        for (int k = 0; k < NUM_UMSG; k++) begin
            if (!any_req && req[rr_ptr + ID_W'(k)]) begin
                any_req = 1'b1;
                winner  = rr_ptr + ID_W'(k);
            end
        end
    end

    // Slot FSMs: data capture, delay countdown and hand-off to the output port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_UMSG; i++) begin
                state[i]  <= S_IDLE;
                timer[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_UMSG; i++) begin
                if (cmd_hit[i]) begin
                    data_q[i] <= cmd_data;
                end
                case (state[i])
                    S_IDLE: begin
                        if (cmd_hit[i]) begin
                            if (cmd_hint && cfg_hint_en) begin
                                state[i] <= S_HINT_WAIT;
                                timer[i] <= hint_delay;
                            end else begin
                                state[i] <= S_DATA_WAIT;
                                timer[i] <= data_delay;
                            end
                        end
                    end
                    S_HINT_WAIT: begin
                        if (timer[i] == '0) begin
                            state[i] <= S_SEND_HINT;
                        end else begin
                            timer[i] <= timer[i] - TIMER_WIDTH'(1);
                        end
                    end
                    S_SEND_HINT: begin
                        if (win_hit[i]) begin
                            state[i] <= S_DATA_WAIT;
                            timer[i] <= data_delay;
                        end
                    end
                    S_DATA_WAIT: begin
                        if (timer[i] == '0) begin
                            state[i] <= S_SEND_DATA;
                        end else begin
                            timer[i] <= timer[i] - TIMER_WIDTH'(1);
                        end
                    end
                    S_SEND_DATA: begin
                        if (win_hit[i]) begin
                            state[i] <= S_IDLE;
                        end
                    end
                    default: state[i] <= S_IDLE;
                endcase
            end
        end
    end

    // Output register, arbiter pointer and statistics counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_id       <= '0;
            out_hint     <= 1'b0;
            out_data     <= '0;
            rr_ptr       <= '0;
            coalesce_cnt <= '0;
            sent_cnt     <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_id    <= winner;
                out_hint  <= (state[winner] == S_SEND_HINT);
                out_data  <= (state[winner] == S_SEND_HINT) ? '0 : data_q[winner];
                rr_ptr    <= winner + ID_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (coalesce) begin
                coalesce_cnt <= coalesce_cnt + 32'd1;
            end
            if (out_valid && out_ready) begin
                sent_cnt <= sent_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ase_umsg_engine.sv
// tb_ase_umsg_engine: directed vector table for the single-slot flows, plus
// hand-written sequences for coalescing on a hint load, back-pressure,
// mid-operation reset and round-robin ordering.
module tb_ase_umsg_engine;

    localparam int N  = 8;
    localparam int TW = 6;
    localparam int DW = 512;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_hint_en;
    logic [TW-1:0] hint_delay;
    logic [TW-1:0] data_delay;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [IW-1:0] cmd_id;
    logic          cmd_hint;
    logic [DW-1:0] cmd_data;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_id;
    logic          out_hint;
    logic [DW-1:0] out_data;
    logic [N-1:0]  slot_busy;
    logic [31:0]   coalesce_cnt;
    logic [31:0]   sent_cnt;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        logic          cfg_hint_en;
        logic [TW-1:0] hint_delay;
        logic [TW-1:0] data_delay;
        logic          cmd_valid;
        logic [IW-1:0] cmd_id;
        logic          cmd_hint;
        logic [DW-1:0] cmd_data;
        logic          out_ready;
        logic          exp_valid;
        logic [IW-1:0] exp_id;
        logic          exp_hint;
        logic [DW-1:0] exp_data;
        logic [N-1:0]  exp_busy;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ase_umsg_engine #(
        .NUM_UMSG   (N),
        .TIMER_WIDTH(TW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_hint_en (cfg_hint_en),
        .hint_delay  (hint_delay),
        .data_delay  (data_delay),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_id      (cmd_id),
        .cmd_hint    (cmd_hint),
        .cmd_data    (cmd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_id      (out_id),
        .out_hint    (out_hint),
        .out_data    (out_data),
        .slot_busy   (slot_busy),
        .coalesce_cnt(coalesce_cnt),
        .sent_cnt    (sent_cnt)
    );

    // Compare one value, count it, report a mismatch
    task automatic checkOutput(input string name, input logic [639:0] act, input logic [639:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to the sampling point just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic cfg, input int hd, input int dd,
                          input logic cv, input int id, input logic ch, input logic [DW-1:0] cd,
                          input logic ordy, input logic ev, input int eid, input logic eh,
                          input logic [DW-1:0] ed, input logic [N-1:0] eb);
        vec_t v;
        v.cfg_hint_en = cfg;
        v.hint_delay  = TW'(hd);
        v.data_delay  = TW'(dd);
        v.cmd_valid   = cv;
        v.cmd_id      = IW'(id);
        v.cmd_hint    = ch;
        v.cmd_data    = cd;
        v.out_ready   = ordy;
        v.exp_valid   = ev;
        v.exp_id      = IW'(eid);
        v.exp_hint    = eh;
        v.exp_data    = ed;
        v.exp_busy    = eb;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        cfg_hint_en = v.cfg_hint_en;
        hint_delay  = v.hint_delay;
        data_delay  = v.data_delay;
        cmd_valid   = v.cmd_valid;
        cmd_id      = v.cmd_id;
        cmd_hint    = v.cmd_hint;
        cmd_data    = v.cmd_data;
        out_ready   = v.out_ready;
    endtask

    task automatic set_cmd(input logic cv, input int id, input logic ch, input logic [DW-1:0] cd, input int dd);
        cmd_valid  = cv;
        cmd_id     = IW'(id);
        cmd_hint   = ch;
        cmd_data   = cd;
        data_delay = TW'(dd);
    endtask

    // Wait (bounded) for the next output message, check it, then consume it
    task automatic wait_output(input string name, input int eid, input logic eh, input logic [DW-1:0] ed);
        int n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        checkOutput(name, 640'({out_valid, out_id, out_hint, out_data}),
                    640'({1'b1, IW'(eid), eh, ed}));
        step();
    endtask

    // Watchdog so the bench always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence
    initial begin
        int valid_seen;

        // hint flow: hint_delay=3, data_delay=2
        addVec(1, 3, 2, 1, 2, 1, 512'hA5, 1, 0, 0, 0, 0, 8'h04);
        addVec(1, 3, 2, 0, 0, 0, 0,       1, 0, 0, 0, 0, 8'h04);
        addVec(1, 3, 2, 0, 0, 0, 0,       1, 0, 0, 0, 0, 8'h04);
        addVec(1, 3, 2, 0, 0, 0, 0,       1, 0, 0, 0, 0, 8'h04);
        addVec(1, 3, 2, 0, 0, 0, 0,       1, 0, 0, 0, 0, 8'h04);
        addVec(1, 3, 2, 0, 0, 0, 0,       1, 1, 2, 1, 0, 8'h04);
        addVec(1, 3, 2, 0, 0, 0, 0,       1, 0, 0, 0, 0, 8'h04);
        addVec(1, 3, 2, 0, 0, 0, 0,       1, 0, 0, 0, 0, 8'h04);
        addVec(1, 3, 2, 0, 0, 0, 0,       1, 0, 0, 0, 0, 8'h04);
        addVec(1, 3, 2, 0, 0, 0, 0,       1, 1, 2, 0, 512'hA5, 8'h00);
        addVec(1, 3, 2, 0, 0, 0, 0,       1, 0, 0, 0, 0, 8'h00);
        // hint mode disabled, zero data delay
        addVec(0, 3, 0, 1, 0, 1, 512'h3C, 1, 0, 0, 0, 0, 8'h01);
        addVec(0, 3, 0, 0, 0, 0, 0,       1, 0, 0, 0, 0, 8'h01);
        addVec(0, 3, 0, 0, 0, 0, 0,       1, 1, 0, 0, 512'h3C, 8'h00);
        addVec(0, 3, 0, 0, 0, 0, 0,       1, 0, 0, 0, 0, 8'h00);
        // coalescing into slot 1 while in DataWait; later cmd_hint is ignored
        addVec(1, 3, 4, 1, 1, 0, 512'h11, 1, 0, 0, 0, 0, 8'h02);
        addVec(1, 3, 4, 1, 1, 1, 512'h55, 1, 0, 0, 0, 0, 8'h02);
        addVec(1, 3, 4, 1, 1, 1, 512'h66, 1, 0, 0, 0, 0, 8'h02);
        addVec(1, 3, 4, 1, 1, 1, 512'h77, 1, 0, 0, 0, 0, 8'h02);
        addVec(1, 3, 4, 0, 0, 0, 0,       1, 0, 0, 0, 0, 8'h02);
        addVec(1, 3, 4, 0, 0, 0, 0,       1, 0, 0, 0, 0, 8'h02);
        addVec(1, 3, 4, 0, 0, 0, 0,       1, 1, 1, 0, 512'h77, 8'h00);
        addVec(1, 3, 4, 0, 0, 0, 0,       1, 0, 0, 0, 0, 8'h00);

        rst_n       = 1'b1;
        cfg_hint_en = 1'b0;
        hint_delay  = '0;
        data_delay  = '0;
        cmd_valid   = 1'b0;
        cmd_id      = '0;
        cmd_hint    = 1'b0;
        cmd_data    = '0;
        out_ready   = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        checkOutput("reset outputs", 640'({out_valid, out_id, out_hint, out_data, slot_busy}), 640'(0));
        checkOutput("reset counters", 640'({coalesce_cnt, sent_cnt}), 640'(0));
        checkOutput("reset cmd_ready", 640'(cmd_ready), 640'(1));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("vec%0d valid", i), 640'(out_valid), 640'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d busy", i), 640'(slot_busy), 640'(vecs[i].exp_busy));
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d payload", i), 640'({out_id, out_hint, out_data}),
                            640'({vecs[i].exp_id, vecs[i].exp_hint, vecs[i].exp_data}));
            end
        end
        cmd_valid = 1'b0;
        checkOutput("table sent_cnt", 640'(sent_cnt), 640'(4));
        checkOutput("table coalesce_cnt", 640'(coalesce_cnt), 640'(3));

        // Command hits slot 5 on the same edge its hint is loaded
        cfg_hint_en = 1'b1;
        hint_delay  = '0;
        set_cmd(1, 5, 1, 512'h10, 0);
        step();
        cmd_valid = 1'b0;
        step();
        set_cmd(1, 5, 0, 512'h20, 0);
        checkOutput("same-edge cmd_ready", 640'(cmd_ready), 640'(1));
        step();
        cmd_valid = 1'b0;
        checkOutput("same-edge hint", 640'({out_valid, out_id, out_hint, out_data}),
                    640'({1'b1, 3'd5, 1'b1, 512'h0}));
        step();
        wait_output("same-edge data", 5, 0, 512'h20);
        checkOutput("same-edge coalesce_cnt", 640'(coalesce_cnt), 640'(4));
        checkOutput("same-edge sent_cnt", 640'(sent_cnt), 640'(6));

        // Back-pressure: slot 6 stalled on the port, slot 7 parked in SendData
        cfg_hint_en = 1'b0;
        out_ready   = 1'b0;
        set_cmd(1, 6, 0, 512'hBEEF, 0);
        step();
        set_cmd(1, 7, 0, 512'h7777, 0);
        step();
        cmd_valid = 1'b0;
        step();
        set_cmd(1, 7, 0, 512'h9999, 0);
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("stall cycle %0d", c),
                        640'({cmd_ready, out_valid, out_id, out_hint, out_data}),
                        640'({1'b0, 1'b1, 3'd6, 1'b0, 512'hBEEF}));
            step();
        end
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("stall release", 640'({out_valid, out_id, out_hint, out_data}),
                    640'({1'b1, 3'd7, 1'b0, 512'h7777}));
        cmd_id = 3'd7;
        #1;
        checkOutput("stall cmd_ready after", 640'(cmd_ready), 640'(1));
        step();

        // Reset while four slots are busy and a message is on the port
        out_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            set_cmd(1, s, 0, 512'hC0 + 512'(s), 0);
            step();
        end
        set_cmd(1, 4, 0, 512'hC4, 20);
        step();
        cmd_valid = 1'b0;
        checkOutput("pre-reset busy", 640'({out_valid, slot_busy}), 640'({1'b1, 8'h1E}));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid reset outputs", 640'({out_valid, out_id, out_hint, out_data, slot_busy}), 640'(0));
        checkOutput("mid reset counters", 640'({coalesce_cnt, sent_cnt}), 640'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready  = 1'b1;
        valid_seen = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (out_valid) valid_seen++;
        end
        checkOutput("post-reset no output", 640'(valid_seen), 640'(0));
        checkOutput("post-reset idle", 640'({slot_busy, sent_cnt}), 640'(0));

        // Round-robin: slots 0,3,5 reach SendData on the same edge
        set_cmd(1, 0, 0, 512'hA0, 2);
        step();
        set_cmd(1, 3, 0, 512'hA3, 1);
        step();
        set_cmd(1, 5, 0, 512'hA5, 0);
        step();
        cmd_valid = 1'b0;
        step();
        checkOutput("rr all SendData", 640'({out_valid, slot_busy}), 640'({1'b0, 8'h29}));
        wait_output("rr first", 0, 0, 512'hA0);
        wait_output("rr second", 3, 0, 512'hA3);
        wait_output("rr third", 5, 0, 512'hA5);
        set_cmd(1, 1, 0, 512'hB1, 1);
        step();
        set_cmd(1, 4, 0, 512'hB4, 0);
        step();
        cmd_valid = 1'b0;
        step();
        wait_output("rr wrap first", 1, 0, 512'hB1);
        wait_output("rr wrap second", 4, 0, 512'hB4);
        checkOutput("rr sent_cnt", 640'({coalesce_cnt, sent_cnt}), 640'({32'd0, 32'd5}));

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
